// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, shift right/left, parallel load,
// with a frame counter that pulses frame_done after every WIDTH-th shift.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sdi_r,
  input  logic             sdi_l,
  input  logic [WIDTH-1:0] pdi,
  output logic [WIDTH-1:0] pdo,
  output logic             sdo_r,
  output logic             sdo_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  mode_e            mode_op;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift;

  assign mode_op = mode_e'(mode);

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    shift  = 1'b0;
    if (en) begin
      case (mode_op)
        MODE_HOLD: ;
        MODE_SHR: begin
          q_d   = {sdi_r, q_q[WIDTH-1:1]};
          shift = 1'b1;
        end
        MODE_SHL: begin
          q_d   = {q_q[WIDTH-2:0], sdi_l};
          shift = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = pdi;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    // Both directions share one frame count; wrapping marks frame completion.
    if (shift) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign pdo        = q_q;
  assign sdo_r      = q_q[0];
  assign sdo_l      = q_q[WIDTH-1];
  assign shift_cnt  = cnt_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=4): directed steps push hand-computed
// post-edge expectations; a monitor pops and compares one entry after each edge.
module tb_univ_shift_reg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             sdi_r = 1'b0;
  logic             sdi_l = 1'b0;
  logic [WIDTH-1:0] pdi = '0;
  logic [WIDTH-1:0] pdo;
  logic             sdo_r, sdo_l;
  logic [CNT_W-1:0] shift_cnt;
  logic             frame_done;

  typedef struct {
    logic [3:0] pdo;
    logic [1:0] cnt;
    logic       done;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode),
    .sdi_r(sdi_r), .sdi_l(sdi_l), .pdi(pdi), .pdo(pdo),
    .sdo_r(sdo_r), .sdo_l(sdo_l), .shift_cnt(shift_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: compare one queued expectation shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) pulses++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.nm, ".pdo"},   pdo, e.pdo);
        chk({e.nm, ".cnt"},   {2'b00, shift_cnt}, {2'b00, e.cnt});
        chk({e.nm, ".done"},  {3'b000, frame_done}, {3'b000, e.done});
        chk({e.nm, ".sdo_r"}, {3'b000, sdo_r}, {3'b000, e.pdo[0]});
        chk({e.nm, ".sdo_l"}, {3'b000, sdo_l}, {3'b000, e.pdo[3]});
      end
    end
  end

  task automatic step(input logic rn, input logic e, input logic [1:0] m,
                      input logic sr, input logic sl, input logic [3:0] p,
                      input logic [3:0] xp, input logic [1:0] xc, input logic xd,
                      input string nm);
    exp_t x;
    @(negedge clk);
    reset_n = rn; en = e; mode = m; sdi_r = sr; sdi_l = sl; pdi = p;
    x.pdo = xp; x.cnt = xc; x.done = xd; x.nm = nm;
    exp_q.push_back(x);
  endtask

  // reset_n pulsed low only between edges; the following edge must ignore it.
  task automatic glitch(input logic [3:0] xp, input logic [1:0] xc, input string nm);
    exp_t x;
    @(negedge clk);
    en = 1'b0; mode = 2'b01; reset_n = 1'b0;
    #2 reset_n = 1'b1;
    x.pdo = xp; x.cnt = xc; x.done = 1'b0; x.nm = nm;
    exp_q.push_back(x);
  endtask

  initial begin
    // Reset
    step(0, 0, 2'b00, 0, 0, 4'h0, 4'b0000, 2'd0, 0, "rst0");
    step(0, 1, 2'b01, 1, 1, 4'hF, 4'b0000, 2'd0, 0, "rst1");
    // Deserialise right 1,0,1,1
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 2'd1, 0, "desr1");
    step(1, 1, 2'b01, 0, 0, 4'h0, 4'b0100, 2'd2, 0, "desr2");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1010, 2'd3, 0, "desr3");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1101, 2'd0, 1, "desr4");
    step(1, 1, 2'b00, 0, 0, 4'h0, 4'b1101, 2'd0, 0, "desr_hold");
    // Deserialise left 1,0,1,1
    step(0, 0, 2'b00, 0, 0, 4'h0, 4'b0000, 2'd0, 0, "rst2");
    step(1, 1, 2'b10, 0, 1, 4'h0, 4'b0001, 2'd1, 0, "desl1");
    step(1, 1, 2'b10, 1, 0, 4'h0, 4'b0010, 2'd2, 0, "desl2");
    step(1, 1, 2'b10, 0, 1, 4'h0, 4'b0101, 2'd3, 0, "desl3");
    step(1, 1, 2'b10, 0, 1, 4'h0, 4'b1011, 2'd0, 1, "desl4");
    step(1, 0, 2'b10, 0, 1, 4'h0, 4'b1011, 2'd0, 0, "desl_hold");
    // Serialise 4'hA right
    step(1, 1, 2'b11, 1, 1, 4'hA, 4'b1010, 2'd0, 0, "ser_load");
    step(1, 1, 2'b01, 0, 0, 4'h0, 4'b0101, 2'd1, 0, "ser1");
    step(1, 1, 2'b01, 0, 0, 4'h0, 4'b0010, 2'd2, 0, "ser2");
    step(1, 1, 2'b01, 0, 0, 4'h0, 4'b0001, 2'd3, 0, "ser3");
    step(1, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 2'd0, 1, "ser4");
    step(1, 1, 2'b00, 1, 1, 4'h0, 4'b0000, 2'd0, 0, "ser_hold");
    // Hold / enable with mixed-direction frame
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 2'd1, 0, "hold_s1");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1100, 2'd2, 0, "hold_s2");
    step(1, 0, 2'b01, 0, 1, 4'h0, 4'b1100, 2'd2, 0, "hold_en0a");
    step(1, 0, 2'b10, 1, 1, 4'h3, 4'b1100, 2'd2, 0, "hold_en0b");
    step(1, 0, 2'b11, 0, 0, 4'hF, 4'b1100, 2'd2, 0, "hold_en0c");
    step(1, 1, 2'b00, 1, 1, 4'hF, 4'b1100, 2'd2, 0, "hold_mode0");
    step(1, 1, 2'b10, 1, 0, 4'h0, 4'b1000, 2'd3, 0, "hold_s3");
    step(1, 1, 2'b10, 0, 1, 4'h0, 4'b0001, 2'd0, 1, "hold_s4");
    step(1, 1, 2'b00, 0, 0, 4'h0, 4'b0001, 2'd0, 0, "hold_after");
    // Reset mid-frame, then glitch between edges
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 2'd1, 0, "mrst_s1");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1100, 2'd2, 0, "mrst_s2");
    step(0, 1, 2'b01, 1, 0, 4'h0, 4'b0000, 2'd0, 0, "mrst_rst");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 2'd1, 0, "mrst_f1");
    step(1, 1, 2'b01, 0, 0, 4'h0, 4'b0100, 2'd2, 0, "mrst_f2");
    step(1, 1, 2'b01, 0, 0, 4'h0, 4'b0010, 2'd3, 0, "mrst_f3");
    glitch(4'b0010, 2'd3, "glitch");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1001, 2'd0, 1, "mrst_f4");
    // Load mid-frame, then two back-to-back frames
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1100, 2'd1, 0, "ld_s1");
    step(1, 1, 2'b01, 0, 0, 4'h0, 4'b0110, 2'd2, 0, "ld_s2");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1011, 2'd3, 0, "ld_s3");
    step(1, 1, 2'b11, 0, 0, 4'h5, 4'b0101, 2'd0, 0, "ld_load");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1010, 2'd1, 0, "b2b1");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1101, 2'd2, 0, "b2b2");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1110, 2'd3, 0, "b2b3");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1111, 2'd0, 1, "b2b4");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1111, 2'd1, 0, "b2b5");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1111, 2'd2, 0, "b2b6");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1111, 2'd3, 0, "b2b7");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b1111, 2'd0, 1, "b2b8");
    step(1, 1, 2'b00, 0, 0, 4'h0, 4'b1111, 2'd0, 0, "b2b_hold");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    checks++;
    if (pulses != 7) begin
      errors++;
      $display("FAIL pulse_count: got %0d expected 7", pulses);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; successor to the fixed 4-bit SISO stage.
- Supports hold, shift-right, shift-left and parallel load, with serial and parallel outputs.
- Built-in frame counter flags each completed WIDTH-bit serial frame.
- Used as the generic serialiser/deserialiser stage for the serial-link and shift-register exercises.

Parameters:
- WIDTH, 8, register length in bits; legal range >= 2.
- CNT_W, $clog2(WIDTH), width of shift_cnt; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- en  input  1  operation enable; 0 = hold regardless of mode
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- sdi_r  input  1  serial in for shift right, enters MSB
- sdi_l  input  1  serial in for shift left, enters LSB
- pdi  input  WIDTH  parallel load data
- pdo  output  WIDTH  register contents (q)
- sdo_r  output  1  q[0], right-shift serial out
- sdo_l  output  1  q[WIDTH-1], left-shift serial out
- shift_cnt  output  CNT_W  shifts completed in current frame
- frame_done  output  1  one-cycle pulse after the WIDTH-th shift of a frame

Behaviour:
- Clock and reset:
  - Single clock domain; all state changes on rising clk only.
  - Reset: reset_n sampled at the rising edge. Low -> q=0, shift_cnt=0, frame_done=0.
  - Reset has priority over en and mode.
  - Deasserting reset_n between edges has no effect until the next edge.
- Outputs:
  - pdo, shift_cnt and frame_done are registered.
  - sdo_r and sdo_l are direct wires from q (no extra latency); both read 0 after reset.
- Operations (en=1):
  - mode=01: q <= {sdi_r, q[WIDTH-1:1]}.
  - mode=10: q <= {q[WIDTH-2:0], sdi_l}.
  - mode=11: q <= pdi; shift_cnt <= 0; frame_done <= 0.
  - mode=00, or en=0: q, shift_cnt unchanged; frame_done <= 0.
- Frame counter:
  - Every shift (01 or 10) with shift_cnt < WIDTH-1: shift_cnt increments, frame_done <= 0.
  - Shift with shift_cnt == WIDTH-1: shift_cnt wraps to 0, frame_done <= 1.
  - frame_done is therefore high for exactly the one cycle following the WIDTH-th shift edge.
  - Shifts in both directions count toward the same frame; mixed-direction frames are legal.
  - Back-to-back frames give one frame_done pulse every WIDTH shift cycles, never stretched.
  - Hold cycles inside a frame pause the counter and do not reset it.
- Latency:
  - Serial-to-parallel: a bit presented before edge k is in MSB (right) or LSB (left) after edge k.
  - Full word valid on pdo in the same cycle frame_done is high.
- Illegal or unknown mode: none; all 4 encodings are defined.

Test Plan:
- Deserialise right: WIDTH=4, after reset, mode=01, en=1, sdi_r = 1,0,1,1 on 4 edges -> pdo = 4'b1101, shift_cnt = 0, frame_done = 1 for one cycle only.
- Deserialise left: WIDTH=4, mode=10, sdi_l = 1,0,1,1 -> pdo steps 0001, 0010, 0101, 1011; frame_done pulses after the 4th edge.
- Serialise: load pdi = 4'hA (mode=11), then mode=01, sdi_r=0 for 4 edges -> sdo_r before each edge = 0,1,0,1; final pdo = 0000; frame_done pulses once.
- Hold/enable: shift 2 bits, then en=0 for 3 cycles with toggling mode/sdi -> pdo and shift_cnt=2 frozen. 2 more shifts -> frame_done after the 4th shift total.
- Reset mid-frame: shift 2 bits, pull reset_n low for 1 edge -> pdo=0, shift_cnt=0, frame_done=0. Then 4 shifts are needed for the next frame_done. reset_n low between edges only -> no change.
- Load mid-frame: after 3 shifts, load pdi=4'h5 -> pdo=0101, shift_cnt=0, no frame_done. Back-to-back 8 shifts -> exactly 2 frame_done pulses, 4 cycles apart.
